traffic_controller: RTL

Timed state machine that drives the 7-bit lamp vector consumed by the LED output stage. It sequences main-street, side-street and pedestrian phases from a tick prescaler. A side-street car sensor shapes the phase lengths, and a latched walk request adds an all-red pedestrian phase. It sits directly upstream of the LED decoder: its `signal` output connects bit-for-bit to that block's `signal` input.

---
 rtl/traffic_pkg.sv | 63 ++++++
 rtl/tick_prescaler.sv | 42 ++++
 rtl/traffic_controller.sv | 139 +++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and the LED output stage.
//
// Contents:
//   - state_e        : 3-bit FSM state encoding (MG1, MG2, MY, SG1, SG2, SY, WALK)
//   - SIG_*          : bit positions inside the 7-bit lamp vector
//   - PAT_*          : lamp patterns driven in each phase
//   - state_pattern  : state -> lamp pattern lookup
//   - pattern_legal  : true for the five lamp patterns that may ever be shown
//   - max_u          : constant helper for sizing counters
package traffic_pkg;

  localparam int unsigned SigW = 7;

  // Bit positions inside the lamp vector.
  localparam int unsigned SIG_R_M  = 0;
  localparam int unsigned SIG_Y_M  = 1;
  localparam int unsigned SIG_G_M  = 2;
  localparam int unsigned SIG_R_S  = 3;
  localparam int unsigned SIG_Y_S  = 4;
  localparam int unsigned SIG_G_S  = 5;
  localparam int unsigned SIG_WALK = 6;

  typedef enum logic [2:0] {
    StMg1  = 3'd0,
    StMg2  = 3'd1,
    StMy   = 3'd2,
    StSg1  = 3'd3,
    StSg2  = 3'd4,
    StSy   = 3'd5,
    StWalk = 3'd6
  } state_e;

  // Lamp patterns, written MSB (walk) first.
  localparam logic [SigW-1:0] PAT_MG   = 7'b0001100;  // g_m, r_s
  localparam logic [SigW-1:0] PAT_MY   = 7'b0001010;  // y_m, r_s
  localparam logic [SigW-1:0] PAT_SG   = 7'b0100001;  // r_m, g_s
  localparam logic [SigW-1:0] PAT_SY   = 7'b0010001;  // r_m, y_s
  localparam logic [SigW-1:0] PAT_WALK = 7'b1001001;  // r_m, r_s, walk

  function automatic logic [SigW-1:0] state_pattern(input state_e s);
    logic [SigW-1:0] p;
    unique case (s)
      StMg1, StMg2: p = PAT_MG;
      StMy:         p = PAT_MY;
      StSg1, StSg2: p = PAT_SG;
      StSy:         p = PAT_SY;
      StWalk:       p = PAT_WALK;
      // Unused code maps to the reset pattern; the FSM leaves it on the next edge.
      default:      p = PAT_MG;
    endcase
    return p;
  endfunction

  function automatic logic pattern_legal(input logic [SigW-1:0] p);
    return (p == PAT_MG) || (p == PAT_MY) || (p == PAT_SG) ||
           (p == PAT_SY) || (p == PAT_WALK);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider producing the timing tick.
//
// Parameters:
//   TICK_DIV : clocks per tick (>= 2)
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, counter returns to 0
//   tick  : one-cycle pulse on every TICK_DIV-th clock; the first pulse is
//           consumed by the TICK_DIV-th rising edge after reset release
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (cnt_q == CntMax) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded straight from the register, so the pulse is glitch-free and
  // depends on no input.
  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/traffic_controller.sv
// Timed traffic-light sequencer for a main/side street crossing with a
// pedestrian phase.
//
// Parameters:
//   TICK_DIV : clocks per timing tick (>= 2)
//   T_BASE   : main/side base green length in ticks
//   T_EXT    : side-green extension in ticks
//   T_YEL    : yellow length in ticks
//   T_WALK   : all-red walk phase length in ticks
// Ports:
//   clk      : clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   sensor   : side-street car present (synchronous level)
//   walk_req : pedestrian button (synchronous pulse or level)
//   signal   : registered lamp vector {walk, g_s, y_s, r_s, g_m, y_m, r_m}
//   state_o  : current state code, debug only
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned T_BASE   = 6,
  parameter int unsigned T_EXT    = 3,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_WALK   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sensor,
  input  logic            walk_req,
  output logic [SigW-1:0] signal,
  output logic [2:0]      state_o
);

  localparam int unsigned TMax = max_u(max_u(T_BASE, T_EXT), max_u(T_YEL, T_WALK));
  localparam int unsigned TmrW = $clog2(TMax + 1);

  state_e          state_q, state_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            walk_pend_q, walk_pend_d;
  logic [SigW-1:0] signal_q, signal_d;

  logic            tick;
  logic [TmrW-1:0] dur_m1;
  logic            state_done;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Last tick-count value of the current state (duration - 1).
  always_comb begin
    dur_m1 = TmrW'(T_BASE - 1);
    unique case (state_q)
      StMy, StSy: dur_m1 = TmrW'(T_YEL - 1);
      StSg2:      dur_m1 = TmrW'(T_EXT - 1);
      StWalk:     dur_m1 = TmrW'(T_WALK - 1);
      default:    dur_m1 = TmrW'(T_BASE - 1);
    endcase
  end

  assign state_done = tick && (timer_q == dur_m1);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    walk_pend_d = walk_pend_q;

    if (tick) begin
      timer_d = timer_q + TmrW'(1);
    end

    unique case (state_q)
      StMg1: begin
        // Sensor only matters on the terminating tick; a busy side street
        // cuts the main green short.
        if (state_done) state_d = sensor ? StMy : StMg2;
      end
      StMg2: begin
        if (state_done) state_d = StMy;
      end
      StMy: begin
        if (state_done) state_d = StSg1;
      end
      StSg1: begin
        if (state_done) state_d = sensor ? StSg2 : StSy;
      end
      StSg2: begin
        if (state_done) state_d = StSy;
      end
      StSy: begin
        // A press landing on the terminating edge counts even though it
        // never reaches the latch.
        if (state_done) state_d = (walk_pend_q || walk_req) ? StWalk : StMg1;
      end
      StWalk: begin
        if (state_done) state_d = StMg1;
      end
      default: begin
        state_d = StMg1;
      end
    endcase

    // No state transitions to itself, so any change is a state entry.
    if (state_d != state_q) begin
      timer_d = '0;
    end

    if ((state_d == StWalk) && (state_q != StWalk)) begin
      walk_pend_d = 1'b0;
    end else if (walk_req && (state_q != StWalk)) begin
      walk_pend_d = 1'b1;
    end

    // Lamps follow the next state so they change on the same edge as state_q.
    signal_d = state_pattern(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StMg1;
      timer_q     <= '0;
      walk_pend_q <= 1'b0;
      signal_q    <= PAT_MG;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      walk_pend_q <= walk_pend_d;
      signal_q    <= signal_d;
    end
  end

  assign signal  = signal_q;
  assign state_o = state_q;

endmodule
